// File: rtl/fetch_align_16.sv
// rtl/fetch_align_16.sv - halfword fetch aligner returning right-aligned RVC/32-bit instructions.
// Optional FETCH_HWBUF_EN adds a one-entry halfword buffer that bypasses the icache on address match.
module fetch_align_16 #(
    parameter int ADDR_WIDTH  = 32,
    parameter bit COMP_DETECT = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  cpu_valid_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    output logic                  cpu_ready_o,
    output logic [31:0]           cpu_rdata_o,
    output logic                  cpu_is_comp_o,
    output logic                  cache_valid_o,
    output logic [ADDR_WIDTH-1:0] cache_addr_o,
    input  logic                  cache_ready_i,
    input  logic [15:0]           cache_rdata_i
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_LO,
        GAP,
        REQ_HI,
        RESP,
        WAIT_DROP
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]           lo_q, lo_d;
    logic                  cpu_ready_q, cpu_ready_d;
    logic [31:0]           cpu_rdata_q, cpu_rdata_d;
    logic                  cpu_is_comp_q, cpu_is_comp_d;
    logic                  cache_valid_q, cache_valid_d;
    logic [ADDR_WIDTH-1:0] cache_addr_q, cache_addr_d;
    logic [ADDR_WIDTH-1:0] pc_hi;

`ifdef FETCH_HWBUF_EN
    logic                  buf_valid_q, buf_valid_d;
    logic [ADDR_WIDTH-1:0] buf_addr_q, buf_addr_d;
    logic [15:0]           buf_data_q, buf_data_d;
`endif

    // Second halfword address wraps naturally at 2^ADDR_WIDTH.
    assign pc_hi = pc_q + ADDR_WIDTH'(2);

    function automatic logic is_rvc(input logic [15:0] hw);
        return COMP_DETECT && (hw[1:0] != 2'b11);
    endfunction

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        lo_d          = lo_q;
        cpu_ready_d   = 1'b0;
        cpu_rdata_d   = cpu_rdata_q;
        cpu_is_comp_d = cpu_is_comp_q;
        cache_valid_d = cache_valid_q;
        cache_addr_d  = cache_addr_q;
`ifdef FETCH_HWBUF_EN
        buf_valid_d   = buf_valid_q;
        buf_addr_d    = buf_addr_q;
        buf_data_d    = buf_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (cpu_valid_i) begin
                    pc_d    = cpu_addr_i;
                    pc_d[0] = 1'b0;
`ifdef FETCH_HWBUF_EN
                    if (buf_valid_q && (buf_addr_q == pc_d)) begin
                        lo_d = buf_data_q;
                        if (is_rvc(buf_data_q)) begin
                            cpu_rdata_d   = {16'h0, buf_data_q};
                            cpu_is_comp_d = 1'b1;
                            cpu_ready_d   = 1'b1;
                            state_d       = RESP;
                        end else begin
                            state_d = GAP;
                        end
                    end else begin
                        cache_addr_d  = pc_d;
                        cache_valid_d = 1'b1;
                        state_d       = REQ_LO;
                    end
`else
                    cache_addr_d  = pc_d;
                    cache_valid_d = 1'b1;
                    state_d       = REQ_LO;
`endif
                end
            end
            REQ_LO: begin
                if (!cpu_valid_i) begin
                    cache_valid_d = 1'b0;
                    state_d       = IDLE;
                end else if (cache_ready_i) begin
                    lo_d          = cache_rdata_i;
                    cache_valid_d = 1'b0;
`ifdef FETCH_HWBUF_EN
                    buf_valid_d   = 1'b1;
                    buf_addr_d    = pc_q;
                    buf_data_d    = cache_rdata_i;
`endif
                    if (is_rvc(cache_rdata_i)) begin
                        cpu_rdata_d   = {16'h0, cache_rdata_i};
                        cpu_is_comp_d = 1'b1;
                        cpu_ready_d   = 1'b1;
                        state_d       = RESP;
`ifdef FETCH_HWBUF_EN
                    end else if (buf_valid_q && (buf_addr_q == pc_hi)) begin
                        cpu_rdata_d   = {buf_data_q, cache_rdata_i};
                        cpu_is_comp_d = 1'b0;
                        cpu_ready_d   = 1'b1;
                        state_d       = RESP;
`endif
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                // The icache needs one idle cycle between back-to-back reads.
                if (!cpu_valid_i) begin
                    state_d = IDLE;
                end else begin
                    cache_addr_d  = pc_hi;
                    cache_valid_d = 1'b1;
                    state_d       = REQ_HI;
                end
            end
            REQ_HI: begin
                if (!cpu_valid_i) begin
                    cache_valid_d = 1'b0;
                    state_d       = IDLE;
                end else if (cache_ready_i) begin
                    cpu_rdata_d   = {cache_rdata_i, lo_q};
                    cpu_is_comp_d = 1'b0;
                    cache_valid_d = 1'b0;
                    cpu_ready_d   = 1'b1;
                    state_d       = RESP;
`ifdef FETCH_HWBUF_EN
                    buf_valid_d   = 1'b1;
                    buf_addr_d    = pc_hi;
                    buf_data_d    = cache_rdata_i;
`endif
                end
            end
            RESP: begin
                state_d = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (!cpu_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            lo_q          <= '0;
            cpu_ready_q   <= 1'b0;
            cpu_rdata_q   <= '0;
            cpu_is_comp_q <= 1'b0;
            cache_valid_q <= 1'b0;
            cache_addr_q  <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            lo_q          <= lo_d;
            cpu_ready_q   <= cpu_ready_d;
            cpu_rdata_q   <= cpu_rdata_d;
            cpu_is_comp_q <= cpu_is_comp_d;
            cache_valid_q <= cache_valid_d;
            cache_addr_q  <= cache_addr_d;
        end
    end

`ifdef FETCH_HWBUF_EN
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_addr_q  <= buf_addr_d;
            buf_data_q  <= buf_data_d;
        end
    end
`endif

    assign cpu_ready_o   = cpu_ready_q;
    assign cpu_rdata_o   = cpu_rdata_q;
    assign cpu_is_comp_o = cpu_is_comp_q;
    assign cache_valid_o = cache_valid_q;
    assign cache_addr_o  = cache_addr_q;

endmodule

// File: tb/tb_fetch_align_16.sv
// tb/tb_fetch_align_16.sv - scoreboard bench for fetch_align_16 with a 1-cycle-hit icache model.
module tb_fetch_align_16;

    logic        clk = 1'b0;
    logic        reset;
    logic        inj_reset;
    logic        dut_reset;
    logic        cpu_valid;
    logic [31:0] cpu_addr;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_is_comp;
    logic        cache_valid;
    logic [31:0] cache_addr;
    logic        cache_ready;
    logic [15:0] cache_rdata;

    logic        arm_reset;
    logic [31:0] arm_addr;
    logic        was_valid;
    logic        prev_cv;
    int          cyc;
    int          last_rdy;
    int          checks;
    int          errors;

    typedef struct packed {
        logic [31:0] addr;
        logic        gap_chk;
    } cexp_t;

    typedef struct packed {
        logic [31:0] data;
        logic        comp;
        logic        lat_chk;
    } pexp_t;

    cexp_t cq[$];
    pexp_t pq[$];

    assign dut_reset = reset | inj_reset;

    fetch_align_16 #(.ADDR_WIDTH(32), .COMP_DETECT(1'b1)) dut (
        .clk_i        (clk),
        .reset_i      (dut_reset),
        .cpu_valid_i  (cpu_valid),
        .cpu_addr_i   (cpu_addr),
        .cpu_ready_o  (cpu_ready),
        .cpu_rdata_o  (cpu_rdata),
        .cpu_is_comp_o(cpu_is_comp),
        .cache_valid_o(cache_valid),
        .cache_addr_o (cache_addr),
        .cache_ready_i(cache_ready),
        .cache_rdata_i(cache_rdata)
    );

    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_rd(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 16'h4501;
            32'h0000_0104: return 16'h0513;
            32'h0000_0106: return 16'h0000;
            32'h0000_010E: return 16'h0297;
            32'h0000_0110: return 16'h1234;
            32'hFFFF_FFFE: return 16'h00B3;
            32'h0000_0000: return 16'hABCD;
            32'h0000_0200: return 16'h8082;
            default:       return 16'hFFFF;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // icache model: ready one cycle after valid is seen, then a one-cycle pulse.
    initial begin
        cache_ready = 1'b0;
        cache_rdata = 16'h0;
        inj_reset   = 1'b0;
        was_valid   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cache_ready) begin
                cache_ready = 1'b0;
                inj_reset   = 1'b0;
                was_valid   = 1'b0;
            end else if (cache_valid && was_valid) begin
                cache_ready = 1'b1;
                cache_rdata = mem_rd(cache_addr);
                if (arm_reset && cache_addr == arm_addr) inj_reset = 1'b1;
            end else begin
                was_valid = cache_valid;
            end
        end
    end

    initial begin
        prev_cv  = 1'b0;
        last_rdy = -100;
    end

    always @(negedge clk) begin
        cexp_t ce;
        pexp_t pe;
        if (cache_valid && !prev_cv) begin
            if (cq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cache_req: got addr %08h expected no request", cache_addr);
            end else begin
                ce = cq.pop_front();
                chk("cache_addr", cache_addr, ce.addr);
                if (ce.gap_chk) chk("hi_req_delay", 32'(cyc - last_rdy), 32'd2);
            end
        end
        if (cpu_ready) begin
            if (pq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cpu_ready: got rdata %08h expected no completion", cpu_rdata);
            end else begin
                pe = pq.pop_front();
                chk("cpu_rdata", cpu_rdata, pe.data);
                chk("cpu_is_comp", {31'h0, cpu_is_comp}, {31'h0, pe.comp});
                if (pe.lat_chk) chk("ready_latency", 32'(cyc - last_rdy), 32'd1);
            end
        end
        if (cache_ready) last_rdy = cyc;
        prev_cv = cache_valid;
    end

    task automatic push_c(input logic [31:0] a, input logic g);
        cexp_t e;
        e.addr    = a;
        e.gap_chk = g;
        cq.push_back(e);
    endtask

    task automatic push_p(input logic [31:0] d, input logic c, input logic l);
        pexp_t e;
        e.data    = d;
        e.comp    = c;
        e.lat_chk = l;
        pq.push_back(e);
    endtask

    task automatic do_fetch(input logic [31:0] a, input int hold);
        int n;
        int busy;
        @(posedge clk);
        #1;
        cpu_valid = 1'b1;
        cpu_addr  = a;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_ready && n < 40);
        if (!cpu_ready) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: got no cpu_ready for pc %08h expected one within 40 cycles", a);
        end
        busy = 0;
        repeat (hold) begin
            @(negedge clk);
            if (cache_valid) busy++;
        end
        if (hold > 0) chk("hold_no_req", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        int n;
        int busy;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        cpu_valid = 1'b0;
        cpu_addr  = 32'h0;
        arm_reset = 1'b0;
        arm_addr  = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_cpu_ready", {31'h0, cpu_ready}, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_cpu_is_comp", {31'h0, cpu_is_comp}, 32'h0);
        chk("rst_cache_valid", {31'h0, cache_valid}, 32'h0);
        chk("rst_cache_addr", cache_addr, 32'h0);

        push_c(32'h100, 1'b0);
        push_p(32'h0000_4501, 1'b1, 1'b1);
        do_fetch(32'h100, 0);

`ifdef FETCH_HWBUF_EN
        push_p(32'h0000_4501, 1'b1, 1'b0);
`else
        push_c(32'h100, 1'b0);
        push_p(32'h0000_4501, 1'b1, 1'b1);
`endif
        do_fetch(32'h100, 0);

        push_c(32'h104, 1'b0);
        push_c(32'h106, 1'b1);
        push_p(32'h0000_0513, 1'b0, 1'b1);
        do_fetch(32'h104, 5);

        push_c(32'h10E, 1'b0);
        push_c(32'h110, 1'b1);
        push_p(32'h1234_0297, 1'b0, 1'b1);
        do_fetch(32'h10E, 0);

        push_c(32'hFFFF_FFFE, 1'b0);
        push_c(32'h0000_0000, 1'b1);
        push_p(32'hABCD_00B3, 1'b0, 1'b1);
        do_fetch(32'hFFFF_FFFE, 0);

        push_c(32'h200, 1'b0);
        push_p(32'h0000_8082, 1'b1, 1'b1);
        do_fetch(32'h201, 0);

        // Abort: drop cpu_valid in the GAP cycle after the low halfword returns.
        push_c(32'h104, 1'b0);
        @(posedge clk);
        #1;
        cpu_valid = 1'b1;
        cpu_addr  = 32'h104;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cache_ready && n < 40);
        if (!cache_ready) begin
            checks++;
            errors++;
            $display("FAIL abort_timeout: got no cache_ready expected one within 40 cycles");
        end
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        busy = 0;
        repeat (5) begin
            @(negedge clk);
            if (cache_valid || cpu_ready) busy++;
        end
        chk("abort_quiet", 32'(busy), 32'd0);

        // Reset asserted in the REQ_HI cycle that also carries cache_ready.
`ifndef FETCH_HWBUF_EN
        push_c(32'h104, 1'b0);
        push_c(32'h106, 1'b1);
`else
        push_c(32'h106, 1'b0);
`endif
        arm_reset = 1'b1;
        arm_addr  = 32'h106;
        @(posedge clk);
        #1;
        cpu_valid = 1'b1;
        cpu_addr  = 32'h104;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!inj_reset && n < 40);
        if (!inj_reset) begin
            checks++;
            errors++;
            $display("FAIL reset_inject_timeout: got no REQ_HI response expected one within 40 cycles");
        end
        @(posedge clk);
        #1;
        cpu_valid = 1'b0;
        arm_reset = 1'b0;
        @(negedge clk);
        chk("hirst_cpu_ready", {31'h0, cpu_ready}, 32'h0);
        chk("hirst_cpu_rdata", cpu_rdata, 32'h0);
        chk("hirst_cpu_is_comp", {31'h0, cpu_is_comp}, 32'h0);
        chk("hirst_cache_valid", {31'h0, cache_valid}, 32'h0);
        chk("hirst_cache_addr", cache_addr, 32'h0);
        @(posedge clk);

        push_c(32'h10E, 1'b0);
        push_c(32'h110, 1'b1);
        push_p(32'h1234_0297, 1'b0, 1'b1);
        do_fetch(32'h10E, 0);

        repeat (5) @(posedge clk);
        chk("cache_q_drained", 32'(cq.size()), 32'd0);
        chk("cpu_q_drained", 32'(pq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
